// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the time-shared 4-bit comparator arbiter.
package cmp_share_pkg;

  localparam int CMP_W    = 4;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  localparam int IDW_MAX  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } st_e;

  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic               lt;
  } cmp_rsp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned less-than comparator among NREQ
// clients, with a single registered response slot and backpressure.
module cmp_share_arbiter
  import cmp_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int W    = CMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_lt,
  output logic [7:0]        busy_cnt
);

  // Handshake: a request transfers when req_valid[i] & req_ready[i]; a
  // response transfers when rsp_valid & rsp_ready, and rsp_* hold otherwise.

  st_e             state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            slot_free;
  logic            xfer;
  logic [W-1:0]    sel_x;
  logic [W-1:0]    sel_y;
  logic            cmp_lt;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A full slot frees up in the same cycle the consumer drains it.
  assign slot_free = (state == EMPTY) | rsp_ready;
  assign xfer      = gnt_any & slot_free & rst_n;
  assign req_ready = (slot_free & rst_n) ? gnt : '0;

  assign sel_x  = req_x[gnt_idx*W +: W];
  assign sel_y  = req_y[gnt_idx*W +: W];
  assign cmp_lt = (sel_x < sel_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_lt    <= cmp_lt;
          end
        end
        FULL: begin
          if (rsp_ready) begin
            if (xfer) begin
              rsp_id <= gnt_idx;
              rsp_lt <= cmp_lt;
            end else begin
              state     <= EMPTY;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (xfer) begin
      ptr <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 8'd0;
    end else if ((|req_valid) && !slot_free && (busy_cnt != 8'hFF)) begin
      busy_cnt <= busy_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of outstanding responses.
module tb_cmp_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_lt;
  logic [7:0]        busy_cnt;

  cmp_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lt    (rsp_lt),
    .busy_cnt  (busy_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [IDW:0] exp_q[$];   // outstanding response: {id, lt}
  int           m_ptr;
  int           m_busy;
  int           last_gnt;
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] op_x(input int i);
    return req_x[i*W +: W];
  endfunction

  function automatic logic [W-1:0] op_y(input int i);
    return req_y[i*W +: W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr    = NREQ - 1;
    m_busy   = 0;
    last_gnt = -1;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic            free;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [IDW:0]    head;
    #1;
    free    = (exp_q.size() == 0) || rsp_ready;
    g       = free ? pick(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("rsp_id", 32'(rsp_id), 32'(head[IDW:1]));
      check("rsp_lt", 32'(rsp_lt), 32'(head[0]));
    end
    check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
    if ((|req_valid) && !free && m_busy < 255) m_busy++;
    if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({IDW'(g), (op_x(g) < op_y(g))});
      m_ptr = g;
    end
    last_gnt = g;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] bx[4] = '{4'd0, 4'd15, 4'd0, 4'd14};
  logic [W-1:0] by[4] = '{4'd15, 4'd0, 4'd0, 4'd15};
  logic         bl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    req_x     = '0;
    req_y     = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: idle after reset
    rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) cycle();
    check("t1_busy", 32'(busy_cnt), 32'd0);

    // 2: single requester 2, then equal operands
    set_req(2, 4'd3, 4'd9);
    req_valid = 4'b0100;
    #1 check("t2_ready", 32'(req_ready), 32'b0100);
    cycle();
    req_valid = '0;
    #1 check("t2_valid", 32'(rsp_valid), 32'd1);
    check("t2_id", 32'(rsp_id), 32'd2);
    check("t2_lt", 32'(rsp_lt), 32'd1);
    cycle();
    set_req(2, 4'd9, 4'd9);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    #1 check("t2_eq_lt", 32'(rsp_lt), 32'd0);
    cycle();
    cycle();

    // 3: all four requesting, round-robin order
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, W'(i), 4'd2);
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("t3_order", 32'(last_gnt), 32'(k % NREQ));
    end
    req_valid = '0;
    cycle();
    cycle();

    // 4: backpressure
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    rsp_ready = 1'b1;
    #1 check("t4_busy", 32'(busy_cnt), 32'd5);
    check("t4_next", 32'(req_ready), 32'b0010);
    cycle();
    req_valid = '0;
    cycle();
    cycle();

    // 5: boundary operands back-to-back through requester 1
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_req(1, bx[k], by[k]);
      if (k > 0) begin
        #1 check("t5_lt", 32'(rsp_lt), 32'(bl[k-1]));
      end
      cycle();
    end
    req_valid = '0;
    #1 check("t5_lt_last", 32'(rsp_lt), 32'(bl[3]));
    cycle();
    cycle();

    // 6: asynchronous reset while FULL
    do_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1001;
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_drop", 32'(rsp_valid), 32'd0);
    check("t6_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rsp_ready = 1'b1;
    cycle();
    check("t6_first", 32'(last_gnt), 32'd0);

    // random traffic, requesters hold valid and operands until granted
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && last_gnt == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // long stall to reach busy_cnt saturation
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int n = 0; n < 270; n++) cycle();
    #1 check("sat_busy", 32'(busy_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
Time-shares one 4-bit unsigned less-than comparator among NREQ requesters. Uses round-robin arbitration with a valid/ready handshake and a single registered response slot with backpressure. Sits between the ALU's comparison clients (branch unit, min/max, sort sequencer) and the shared comparator datapath. Each accepted request produces exactly one tagged response.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester-id width, equals ceil(log2(NREQ))
W, 4, operand width, fixed to comparator width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request strobe
req_x  in  NREQ*W  flattened x operands; requester i uses bits [i*W +: W]
req_y  in  NREQ*W  flattened y operands, same packing
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  index of requester that issued the comparison
rsp_lt  out  1  1 when x < y, unsigned
busy_cnt  out  8  saturating count of cycles with any req_valid high but no grant

Behaviour:
- Reset, asynchronous on rst_n low:
  - rsp_valid=0, rsp_id=0, rsp_lt=0, busy_cnt=0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - State = EMPTY.
  - req_ready=0 while rst_n is low.
- FSM, 2 states, tracks response slot:
  - EMPTY: the slot may accept a request.
    - Any req_valid -> grant, capture the result, go to FULL.
    - Otherwise stay in EMPTY.
  - FULL: rsp_valid=1.
    - rsp_ready=1 and a new request granted in the same cycle -> stay in FULL with the new result (back-to-back, no bubble).
    - rsp_ready=1 and no request -> EMPTY.
    - rsp_ready=0 -> hold all rsp_* outputs stable and grant nothing.
- Slot free condition: `slot_free = (state==EMPTY) | rsp_ready`.
- Grant is combinational: req_ready is nonzero only when slot_free.
  - Grant goes to the first requester with req_valid set, searching upward from pointer+1 modulo NREQ.
  - At most one bit of req_ready is set.
  - req_ready never depends on req_x or req_y.
- Latency:
  - A request transferred in cycle N gives rsp_valid=1 in cycle N+1.
  - rsp_lt = (x<y) from the operands sampled at cycle N.
  - rsp_id = granted index.
  - Throughput is 1 comparison per cycle while rsp_ready=1.
- Pointer updates to the granted index only on a transfer. No transfer means the pointer holds.
- Comparison is unsigned 4-bit:
  - x==y gives 0.
  - x=0, y=15 gives 1.
  - x=15, y=0 gives 0.
- Requesters must hold req_valid and their operands until granted. The arbiter does not check this.
- busy_cnt increments on each cycle where |req_valid & ~slot_free. It saturates at 255 and clears only on reset.
- Reset mid-operation: any pending response is discarded and no rsp is emitted for it. Requesters must re-issue.

Decomposition:
- Package cmp_share_pkg:
  - Constants CMP_W=4, NREQ_DEF=4, IDW_DEF=2.
  - Typedef st_e {EMPTY, FULL}.
  - Typedef cmp_rsp_t {id, lt}.
- Sub-module rr_pick (NREQ):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; reused later by other shared-unit arbiters.
- The comparator is instantiated once inside the block on the muxed granted operands.

Test Plan:
1. Reset then idle: rsp_valid=0 and req_ready=0 for 10 cycles; busy_cnt=0.
2. Single requester 2, x=3, y=9, rsp_ready=1: req_ready=4'b0100 in cycle N; cycle N+1 gives rsp_valid=1, rsp_id=2, rsp_lt=1. Repeat with x=9, y=9 -> rsp_lt=0.
3. All four requesters hold valid with rsp_ready=1: grants arrive in order 0,1,2,3,0 on consecutive cycles with no bubble; responses follow one cycle later in the same order.
4. Backpressure: rsp_ready=0 for 5 cycles with requests pending. rsp_* stays stable, req_ready=0, busy_cnt=5. When rsp_ready=1, the same-cycle grant goes to the next round-robin index.
5. Boundary operands: (0,15) gives lt=1; (15,0) gives lt=0; (0,0) gives lt=0; (14,15) gives lt=1. Run all four back-to-back through requester 1.
6. Assert rst_n low asynchronously, mid-clock, while FULL: rsp_valid drops immediately. After release, requester 0 gets first grant even if requester 3 also requests.
